// File: rtl/sb_trans_gen_param.sv
// Sideband transaction generator: frames LT and AT read/write symbols as
// {stop=1, byte, start=0}, holds each symbol for SYM_CYCLES cycles and flags
// CRC coverage and CRC slots for the downstream serializer/CRC mux.
// Optional feature: define SB_DLE_STUFF_EN to double any 0xFE in ADDR, LEN
// or DATA with an extra 0xFE symbol that is not CRC-covered.
module sb_trans_gen_param #(
  parameter int MAX_DATA_BYTES = 4,
  parameter int SYM_CYCLES     = 10,
  parameter int SENT_DELAY     = 3
) (
  input  logic                        sb_clk,
  input  logic                        rst,
  input  logic [2:0]                  trans_sel,
  input  logic [7:0]                  at_addr,
  input  logic [6:0]                  at_len,
  input  logic [8*MAX_DATA_BYTES-1:0] at_data,
  input  logic [7:0]                  lt_lse,
  input  logic                        disconnect_sbtx,
  input  logic                        tdisconnect_tx_min,
  output logic [9:0]                  trans,
  output logic [1:0]                  trans_state,
  output logic                        crc_en,
  output logic                        sbtx_sel,
  output logic                        busy,
  output logic                        trans_sent,
  output logic                        disconnected_s
);

`ifdef SB_DLE_STUFF_EN
  localparam bit STUFF_EN = 1'b1;
`else
  localparam bit STUFF_EN = 1'b0;
`endif

  localparam int CW = (SYM_CYCLES > 1) ? $clog2(SYM_CYCLES) : 1;
  localparam int DW = (SENT_DELAY > 0) ? $clog2(SENT_DELAY + 1) : 1;

  localparam logic [7:0] DLE_B  = 8'hFE;
  localparam logic [7:0] ETX_B  = 8'h40;
  localparam logic [7:0] STX_CMD = 8'h05;
  localparam logic [7:0] STX_RSP = 8'h04;

  typedef enum logic [3:0] {
    S_DISC, S_IDLE, S_DLE1, S_LSE, S_CLSE, S_STX, S_ADDR, S_LEN,
    S_DATA, S_STUFF, S_CRC1, S_CRC2, S_DLE2, S_ETX
  } state_t;

  state_t                      state, next_state, stuff_from, stuff_from_n;
  state_t                      src, follow_state;
  logic [CW-1:0]               sym_cnt;
  logic [6:0]                  idx, next_idx, follow_idx;
  logic [DW-1:0]               pend_cnt;
  logic                        sym_last, accept, done;

  logic [2:0]                  sel_q;
  logic [7:0]                  addr_q, lse_q;
  logic [6:0]                  len_q, len_c;
  logic [8*MAX_DATA_BYTES-1:0] data_q;

  logic                        is_lt, is_cmd, wnr, has_data;
  logic [7:0]                  len_byte, cur_byte, cur_data, out_data;

  logic [9:0]                  trans_n;
  logic [1:0]                  tstate_n;
  logic                        crc_n, sbtx_n, busy_n, disc_n;

  function automatic logic [9:0] frame(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  assign is_lt    = (sel_q == 3'd1);
  assign is_cmd   = (sel_q == 3'd2) || (sel_q == 3'd4);
  assign wnr      = (sel_q == 3'd4) || (sel_q == 3'd5);
  assign has_data = (sel_q == 3'd4) || (sel_q == 3'd3);
  assign len_c    = (len_q > 7'(MAX_DATA_BYTES)) ? 7'(MAX_DATA_BYTES) : len_q;
  assign len_byte = {wnr, len_c};
  assign sym_last = (sym_cnt == CW'(SYM_CYCLES - 1));

  // Byte currently on the wire (for DLE-doubling) and the symbol that follows it
  always_comb begin
    src          = (state == S_STUFF) ? stuff_from : state;
    cur_data     = 8'h00;
    for (int i = 0; i < MAX_DATA_BYTES; i++)
      if (idx == 7'(i)) cur_data = data_q[8*i +: 8];
    cur_byte     = 8'h00;
    follow_state = S_CRC1;
    follow_idx   = idx;
    case (src)
      S_ADDR: begin
        cur_byte     = addr_q;
        follow_state = S_LEN;
      end
      S_LEN: begin
        cur_byte = len_byte;
        if (has_data && (len_c != 7'd0)) begin
          follow_state = S_DATA;
          follow_idx   = 7'd0;
        end
      end
      S_DATA: begin
        cur_byte = cur_data;
        if (idx != (len_c - 7'd1)) begin
          follow_state = S_DATA;
          follow_idx   = idx + 7'd1;
        end
      end
      default: ;
    endcase
  end

  // Next-state logic; disconnect overrides everything
  always_comb begin
    next_state   = state;
    next_idx     = idx;
    stuff_from_n = stuff_from;
    accept       = 1'b0;
    done         = 1'b0;
    if (disconnect_sbtx) begin
      next_state = S_DISC;
    end else begin
      case (state)
        S_DISC: if (tdisconnect_tx_min) next_state = S_IDLE;
        S_IDLE: begin
          if ((trans_sel >= 3'd1) && (trans_sel <= 3'd5)) begin
            accept     = 1'b1;
            next_state = S_DLE1;
          end
        end
        default: begin
          if (sym_last) begin
            case (state)
              S_DLE1: next_state = is_lt ? S_LSE : S_STX;
              S_LSE:  next_state = S_CLSE;
              S_CLSE: begin
                next_state = S_IDLE;
                done       = 1'b1;
              end
              S_STX:  next_state = S_ADDR;
              S_ADDR, S_LEN, S_DATA: begin
                if (STUFF_EN && (cur_byte == DLE_B)) begin
                  next_state   = S_STUFF;
                  stuff_from_n = state;
                end else begin
                  next_state = follow_state;
                  next_idx   = follow_idx;
                end
              end
              S_STUFF: begin
                next_state = follow_state;
                next_idx   = follow_idx;
              end
              S_CRC1: next_state = S_CRC2;
              S_CRC2: next_state = S_DLE2;
              S_DLE2: next_state = S_ETX;
              S_ETX: begin
                next_state = S_IDLE;
                done       = 1'b1;
              end
              default: next_state = S_DISC;
            endcase
          end
        end
      endcase
    end
  end

  // Output values for the state being entered, so outputs register in step with it
  always_comb begin
    out_data = 8'h00;
    for (int i = 0; i < MAX_DATA_BYTES; i++)
      if (next_idx == 7'(i)) out_data = data_q[8*i +: 8];
    trans_n  = 10'h000;
    tstate_n = 2'd2;
    crc_n    = 1'b0;
    sbtx_n   = 1'b0;
    busy_n   = 1'b1;
    disc_n   = 1'b0;
    case (next_state)
      S_DISC: begin
        tstate_n = 2'd0;
        busy_n   = 1'b0;
        disc_n   = 1'b1;
      end
      S_IDLE: begin
        trans_n  = 10'h3FF;
        tstate_n = 2'd1;
        busy_n   = 1'b0;
      end
      S_DLE1, S_DLE2, S_STUFF: trans_n = frame(DLE_B);
      S_LSE:  trans_n = frame(lse_q);
      S_CLSE: trans_n = frame(~lse_q);
      S_STX: begin
        trans_n = frame(is_cmd ? STX_CMD : STX_RSP);
        crc_n   = 1'b1;
      end
      S_ADDR: begin
        trans_n = frame(addr_q);
        crc_n   = 1'b1;
      end
      S_LEN: begin
        trans_n = frame(len_byte);
        crc_n   = 1'b1;
      end
      S_DATA: begin
        trans_n = frame(out_data);
        crc_n   = 1'b1;
      end
      S_CRC1, S_CRC2: begin
        crc_n  = 1'b1;
        sbtx_n = 1'b1;
      end
      S_ETX:  trans_n = frame(ETX_B);
      default: ;
    endcase
  end

  // FSM state, symbol counter and data byte index
  always_ff @(posedge sb_clk) begin
    if (rst) begin
      state      <= S_DISC;
      sym_cnt    <= '0;
      idx        <= '0;
      stuff_from <= S_ADDR;
    end else begin
      state      <= next_state;
      idx        <= next_idx;
      stuff_from <= stuff_from_n;
      if ((next_state == S_DISC) || (state == S_IDLE) || (state == S_DISC) || sym_last)
        sym_cnt <= '0;
      else
        sym_cnt <= sym_cnt + CW'(1);
    end
  end

  // Capture the request on acceptance; later input changes are ignored
  always_ff @(posedge sb_clk) begin
    if (accept) begin
      sel_q  <= trans_sel;
      addr_q <= at_addr;
      len_q  <= at_len;
      data_q <= at_data;
      lse_q  <= lt_lse;
    end
  end

  // Registered outputs
  always_ff @(posedge sb_clk) begin
    if (rst) begin
      trans          <= 10'h000;
      trans_state    <= 2'd0;
      crc_en         <= 1'b0;
      sbtx_sel       <= 1'b0;
      busy           <= 1'b0;
      disconnected_s <= 1'b1;
    end else begin
      trans          <= trans_n;
      trans_state    <= tstate_n;
      crc_en         <= crc_n;
      sbtx_sel       <= sbtx_n;
      busy           <= busy_n;
      disconnected_s <= disc_n;
    end
  end

  // Delayed completion pulse; an abort to DISCONNECT cancels any pending pulse
  always_ff @(posedge sb_clk) begin
    if (rst || disconnect_sbtx) begin
      pend_cnt   <= '0;
      trans_sent <= 1'b0;
    end else if (done) begin
      if (SENT_DELAY == 0) begin
        trans_sent <= 1'b1;
      end else begin
        pend_cnt   <= DW'(SENT_DELAY);
        trans_sent <= 1'b0;
      end
    end else if (pend_cnt != '0) begin
      pend_cnt   <= pend_cnt - DW'(1);
      trans_sent <= (pend_cnt == DW'(1));
    end else begin
      trans_sent <= 1'b0;
    end
  end

endmodule
